ws2812_serializer: RTL and testbench
====================================

# ws2812_serializer

Downstream stage of the fancy fader. Pulls 8-bit colour bytes on demand via a `data_request` strobe and turns them into the single-wire WS2812 NRZ waveform. Sends a frame of `LEDS*3` bytes, then holds the line low for the latch period. It sits between the fader (which supplies `trigger` and `color_now`) and the output pin driving the LED strip.

## Interface
- `LEDS`, 32, LEDs per frame; frame length is `LEDS*3` bytes.
- `T0H_CYCLES`, 6, high time of a 0-bit, in clk cycles.
- `T1H_CYCLES`, 13, high time of a 1-bit, in clk cycles.
- `BIT_CYCLES`, 20, total bit period; must be greater than `T1H_CYCLES`, which must be greater than `T0H_CYCLES`, which must be ≥1.
- `LATCH_CYCLES`, 1280, minimum low time after a frame (≥80 µs at 16 MHz).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high; clock clk.
- `trigger`  in  1  upstream has a frame ready; level-sensitive.
- `color_now`  in  8  current byte from upstream; valid whenever `trigger` is high.
- `data_request`  out  1  one-cycle strobe: byte consumed on this edge; upstream advances.
- `ws_out`  out  1  registered WS2812 data line.
- `busy`  out  1  high when state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse when the last bit of a frame finishes.

## Operation
- States: IDLE, SEND, LATCH.
- Reset:
  - Enters LATCH with the latch counter at 0.
  - Output reset values: `ws_out`=0, `data_request`=0, `busy`=1, `frame_done`=0.
- IDLE:
  - With `trigger`=1, `data_request` is asserted combinationally in the same cycle.
  - `color_now` is loaded into the shift register at that edge.
  - The byte counter is cleared, bit index is set to 7, phase to 0, and the state moves to SEND.
  - With `trigger`=0, the block stays in IDLE and `ws_out`=0.
- SEND:
  - Phase counter runs 0..`BIT_CYCLES`-1.
  - `ws_out`=1 while phase < (current bit ? `T1H_CYCLES` : `T0H_CYCLES`), else 0.
  - Bits go out MSB first.
  - At the end of bit 0 of a byte, if bytes remain, `data_request`=1 for that cycle and the next byte loads with no gap.
  - After bit 0 of byte `LEDS*3`-1:
    - `frame_done`=1 for one cycle.
    - State moves to LATCH.
- LATCH:
  - `ws_out`=0 for exactly `LATCH_CYCLES` cycles, then IDLE.
  - `trigger` is ignored.
- `trigger` is ignored in SEND and LATCH.
- Byte order on the wire equals request order. Channel ordering (GRB) is the upstream's responsibility.
- Reset mid-frame:
  - `ws_out` goes low at the next edge.
  - The partial frame is abandoned.
  - The full latch period is observed before any new frame, so the strip never sees a truncated frame merged with the next.
- Counter widths: byte `$clog2(LEDS*3)`, phase `$clog2(BIT_CYCLES)`, latch `$clog2(LATCH_CYCLES)`. All counters wrap only under explicit compare; there is no natural overflow.

## Timing
- Latency from IDLE with `trigger`=1 to the first rising `ws_out`: 1 cycle (the cycle after the `data_request` edge).
- Each bit is exactly `BIT_CYCLES` cycles.
- Each byte is `8*BIT_CYCLES` cycles.
- A frame is `LEDS*3*8*BIT_CYCLES` cycles.
- `data_request` spacing within a frame is `8*BIT_CYCLES` cycles.
- Exactly `LEDS*3` requests occur per frame.
- From the `frame_done` cycle to the next possible `data_request`: `LATCH_CYCLES`+1 cycles. This applies when `trigger` is held high.
- `ws_out` has no glitches: it is a register output computed from the next state.

## Configuration
- Macro: `WS2812_SERIALIZER_INVERT_EN`.
  - Defined: `ws_out` is inverted everywhere, for inverting level shifters. The idle/reset/latch level is 1, and high times become low times.
  - Undefined: polarity is as described above.

## Structure
- Package `ws2812_pkg`:
  - State enum `ws2812_state_t` {IDLE, SEND, LATCH}.
  - Default timing constants (`WS2812_T0H`, `WS2812_T1H`, `WS2812_TBIT`, `WS2812_TLATCH`), shared with any future WS2812 blocks.
- Sub-module `ws2812_bit_timer`:
  - Owns the phase counter and high/low comparison.
  - Input: `bit_val`, `start`.
  - Output: `level`, `bit_end`.
- The top level holds the FSM, shift register, and byte/latch counters.

## Test plan
Bench parameters: `LEDS`=2, `T0H_CYCLES`=2, `T1H_CYCLES`=4, `BIT_CYCLES`=6, `LATCH_CYCLES`=10.
- Reset release with `trigger`=1 → `ws_out`=0 and `data_request`=0 for 10 cycles, then `data_request` pulses in the first IDLE cycle.
- Byte 0xA5 loaded → eight 6-cycle periods with high widths 4,2,4,2,2,4,2,4.
- Full frame, `trigger` held → exactly 6 `data_request` pulses spaced 48 cycles, continuous waveform. `frame_done` occurs 288 cycles after the first rising `ws_out`.
- `trigger` held after a frame → 10 low cycles after `frame_done`, then the next `data_request`. A second frame is identical given identical bytes.
- `rst` pulsed mid-byte 3 → `ws_out`=0 next cycle, 10-cycle latch, then a new frame starts at byte 0 with a full 6 requests.
- `WS2812_SERIALIZER_INVERT_EN` defined, byte 0x80 → idle level 1, first bit low for 4 cycles, remaining bits low for 2 cycles each.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 types and default timing constants.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } ws2812_state_t;

  // Defaults for a 16 MHz clock.
  localparam int unsigned WS2812_T0H    = 6;
  localparam int unsigned WS2812_T1H    = 13;
  localparam int unsigned WS2812_TBIT   = 20;
  localparam int unsigned WS2812_TLATCH = 1280;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit phase counter and high/low level generation for the WS2812 line.
// The level register is computed from next-cycle phase and bit value so the
// pin changes exactly on the bit/phase boundaries without glitches.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYCLES = WS2812_T0H,
  parameter int unsigned T1H_CYCLES = WS2812_T1H,
  parameter int unsigned BIT_CYCLES = WS2812_TBIT,
  parameter bit          INVERT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,       // bit stream active in the next cycle
  input  logic start,    // first bit of a frame begins next cycle
  input  logic bit_val,  // bit value active in the next cycle
  output logic level,
  output logic bit_end
);

  localparam int unsigned PH_W = cnt_width(BIT_CYCLES);

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;
  logic [PH_W-1:0] high_len;
  logic            active;
  logic            level_nxt;

  // Last cycle of the current bit period.
  assign bit_end = active && (phase == PH_W'(BIT_CYCLES - 1));

  // Next phase and next line level.
  always_comb begin
    phase_nxt = phase + PH_W'(1);
    if (!en || start || bit_end) begin
      phase_nxt = '0;
    end
    high_len  = bit_val ? PH_W'(T1H_CYCLES) : PH_W'(T0H_CYCLES);
    level_nxt = en && (phase_nxt < high_len);
  end

  // Phase, activity and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      active <= 1'b0;
      level  <= INVERT;
    end else begin
      phase  <= phase_nxt;
      active <= en;
      level  <= level_nxt ^ INVERT;
    end
  end

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 NRZ serializer: requests bytes from upstream on demand, shifts them
// out MSB first and holds the line idle for the latch period between frames.
// Optional: define WS2812_SERIALIZER_INVERT_EN to invert ws_out for inverting
// level shifters (idle level becomes 1).
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned LEDS         = 32,
  parameter int unsigned T0H_CYCLES   = WS2812_T0H,
  parameter int unsigned T1H_CYCLES   = WS2812_T1H,
  parameter int unsigned BIT_CYCLES   = WS2812_TBIT,
  parameter int unsigned LATCH_CYCLES = WS2812_TLATCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] color_now,
  output logic       data_request,
  output logic       ws_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BYTES  = LEDS * 3;
  localparam int unsigned BYTE_W = cnt_width(BYTES);
  localparam int unsigned LAT_W  = cnt_width(LATCH_CYCLES);

`ifdef WS2812_SERIALIZER_INVERT_EN
  localparam bit INVERT = 1'b1;
`else
  localparam bit INVERT = 1'b0;
`endif

  ws2812_state_t     state, state_nxt;
  logic [7:0]        sreg, sreg_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [LAT_W-1:0]  latch_cnt, latch_cnt_nxt;
  logic              timer_start;
  logic              timer_en;
  logic              bit_end;

  // Next-state, datapath and strobe logic.
  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    bit_idx_nxt   = bit_idx;
    byte_cnt_nxt  = byte_cnt;
    latch_cnt_nxt = latch_cnt;
    data_request  = 1'b0;
    frame_done    = 1'b0;
    timer_start   = 1'b0;

    unique case (state)
      IDLE: begin
        if (trigger) begin
          data_request = 1'b1;
          sreg_nxt     = color_now;
          byte_cnt_nxt = '0;
          bit_idx_nxt  = 3'd7;
          timer_start  = 1'b1;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_idx != 3'd0) begin
            sreg_nxt    = {sreg[6:0], 1'b0};
            bit_idx_nxt = bit_idx - 3'd1;
          end else if (byte_cnt == BYTE_W'(BYTES - 1)) begin
            frame_done    = 1'b1;
            latch_cnt_nxt = '0;
            state_nxt     = LATCH;
          end else begin
            data_request = 1'b1;
            sreg_nxt     = color_now;
            byte_cnt_nxt = byte_cnt + BYTE_W'(1);
            bit_idx_nxt  = 3'd7;
          end
        end
      end
      LATCH: begin
        if (latch_cnt == LAT_W'(LATCH_CYCLES - 1)) begin
          latch_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          latch_cnt_nxt = latch_cnt + LAT_W'(1);
        end
      end
      default: begin
        latch_cnt_nxt = '0;
        state_nxt     = LATCH;
      end
    endcase
  end

  // Timer looks at the next cycle's state and bit.
  assign timer_en = (state_nxt == SEND);

  // State and datapath registers; reset forces a full latch period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LATCH;
      sreg      <= '0;
      bit_idx   <= 3'd7;
      byte_cnt  <= '0;
      latch_cnt <= '0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      bit_idx   <= bit_idx_nxt;
      byte_cnt  <= byte_cnt_nxt;
      latch_cnt <= latch_cnt_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  ws2812_bit_timer #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES),
    .INVERT     (INVERT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (timer_en),
    .start   (timer_start),
    .bit_val (sreg_nxt[7]),
    .level   (ws_out),
    .bit_end (bit_end)
  );

endmodule

// File: tb/tb_ws2812_serializer.sv
// Self-checking bench for ws2812_serializer with small timing parameters.
module tb_ws2812_serializer;

  localparam int unsigned LEDS  = 2;
  localparam int unsigned T0H   = 2;
  localparam int unsigned T1H   = 4;
  localparam int unsigned TB    = 6;
  localparam int unsigned TL    = 10;
  localparam int          NB    = 6;
  localparam int          BYTEC = 8 * 6;
  localparam int          FRAME = NB * BYTEC;

`ifdef WS2812_SERIALIZER_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] color_now = 8'h00;
  logic       data_request, ws_out, busy, frame_done;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] frame_bytes [NB];
  int         idx = 0;
  bit         jitter = 1'b0;
  logic       s_ws, s_dr, s_fd, s_bz;

  always #5 clk = ~clk;

  ws2812_serializer #(
    .LEDS         (LEDS),
    .T0H_CYCLES   (T0H),
    .T1H_CYCLES   (T1H),
    .BIT_CYCLES   (TB),
    .LATCH_CYCLES (TL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .color_now    (color_now),
    .data_request (data_request),
    .ws_out       (ws_out),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input int at, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, at, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, then act as upstream after posedge.
  task automatic cycle();
    @(negedge clk);
    s_ws = ws_out;
    s_dr = data_request;
    s_fd = frame_done;
    s_bz = busy;
    @(posedge clk);
    #1;
    if (s_dr === 1'b1) begin
      idx       = (idx + 1) % NB;
      color_now = frame_bytes[idx];
    end
    if (jitter) trigger = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_latch();
    for (int j = 0; j < int'(TL); j++) begin
      cycle();
      chk("latch_ws", j, 32'(s_ws), 32'(INV));
      chk("latch_req", j, 32'(s_dr), 32'd0);
      chk("latch_done", j, 32'(s_fd), 32'd0);
      chk("latch_busy", j, 32'(s_bz), 32'd1);
    end
  endtask

  // Request cycle in IDLE followed by stop_k waveform cycles of the frame.
  task automatic expect_frame(input int stop_k);
    int   hi, rise, done, ph, wid;
    logic bitv, lvl;
    logic [7:0] b;
    idx       = 0;
    color_now = frame_bytes[0];
    cycle();
    chk("req_first", -1, 32'(s_dr), 32'd1);
    chk("idle_ws", -1, 32'(s_ws), 32'(INV));
    chk("idle_busy", -1, 32'(s_bz), 32'd0);
    chk("idle_done", -1, 32'(s_fd), 32'd0);
    hi = 0; rise = -1; done = -1;
    for (int k = 0; k < stop_k; k++) begin
      cycle();
      b    = frame_bytes[k / BYTEC];
      bitv = b[7 - ((k % BYTEC) / int'(TB))];
      ph   = k % int'(TB);
      wid  = bitv ? int'(T1H) : int'(T0H);
      lvl  = (ph < wid);
      chk("ws", k, 32'(s_ws), 32'(lvl ^ INV));
      chk("req", k, 32'(s_dr), 32'((k % BYTEC == BYTEC - 1) && (k / BYTEC < NB - 1)));
      chk("done", k, 32'(s_fd), 32'(k == FRAME - 1));
      chk("busy", k, 32'(s_bz), 32'd1);
      if (s_ws === ~INV) begin
        hi++;
        if (rise < 0) rise = k;
      end
      if (s_fd === 1'b1) done = k;
      if (ph == int'(TB) - 1) begin
        chk("hi_width", k, 32'(hi), 32'(wid));
        hi = 0;
      end
    end
    if (stop_k == FRAME) chk("frame_span", done, 32'(done - rise + 1), 32'(FRAME));
  endtask

  initial begin
    frame_bytes[0] = 8'hA5;
    frame_bytes[1] = 8'h80;
    for (int i = 2; i < NB; i++) frame_bytes[i] = 8'($urandom);
    rst     = 1'b1;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    // Held in reset with trigger high: line idle, no requests.
    repeat (3) begin
      cycle();
      chk("rst_ws", 0, 32'(s_ws), 32'(INV));
      chk("rst_req", 0, 32'(s_dr), 32'd0);
      chk("rst_busy", 0, 32'(s_bz), 32'd1);
      chk("rst_done", 0, 32'(s_fd), 32'd0);
    end
    rst = 1'b0;
    expect_latch();
    expect_frame(FRAME);
    // Trigger held: identical second frame after the latch.
    expect_latch();
    expect_frame(FRAME);
    expect_latch();
    // Trigger low: stay idle.
    trigger = 1'b0;
    repeat (4) begin
      cycle();
      chk("hold_req", 0, 32'(s_dr), 32'd0);
      chk("hold_ws", 0, 32'(s_ws), 32'(INV));
      chk("hold_busy", 0, 32'(s_bz), 32'd0);
      chk("hold_done", 0, 32'(s_fd), 32'd0);
    end
    // New random bytes, trigger toggling during the frame must be ignored.
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom);
    trigger = 1'b1;
    jitter  = 1'b1;
    expect_frame(FRAME);
    jitter  = 1'b0;
    expect_latch();
    // Reset in the middle of byte 3 abandons the frame.
    trigger = 1'b1;
    for (int i = 0; i < NB; i++) frame_bytes[i] = 8'($urandom);
    expect_frame(3 * BYTEC + 6);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expect_latch();
    expect_frame(FRAME);
    expect_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
